// File: rtl/mem_defs.sv
// Shared definitions for the data memory block.
//   - FUNC3 access-width encodings used by loads and stores
//   - FSM state encoding for the access sequencer
//   - lane_mask(): byte-enable for a given width and address offset
package mem_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_DONE   = 2'b10
    } state_t;

    // Undefined encodings fall through to a full-word access.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = 4'b0001 << lo;
            F3_H, F3_HU: m = lo[1] ? 4'b1100 : 4'b0011;
            default:     m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane alignment for byte/halfword/word accesses.
// Ports:
//   func3    in   access width encoding
//   addr_lo  in   byte offset within the word (addr[1:0])
//   rd_word  in   current contents of the addressed word
//   wr_data  in   store data (low byte/half used for SB/SH)
//   byte_en  out  lanes touched by the access
//   st_word  out  rd_word with the enabled lanes replaced by store data
//   ld_data  out  selected lane, sign/zero extended
module load_store_align
    import mem_defs::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [3:0]  byte_en,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [31:0] wr_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        byte_en = lane_mask(func3, addr_lo);

        // Replicate the narrow store value into every lane; byte_en picks the one that lands.
        case (func3)
            F3_B, F3_BU: wr_rep = {4{wr_data[7:0]}};
            F3_H, F3_HU: wr_rep = {2{wr_data[15:0]}};
            default:     wr_rep = wr_data;
        endcase

        st_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                st_word[8*i +: 8] = wr_rep[8*i +: 8];
            end
        end

        ld_byte = rd_word[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

        case (func3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h000000, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = rd_word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory serving the CPU MEM stage.
// Holds BUSYWAIT for LATENCY cycles per access, then completes it.
// Ports:
//   CLK             in   clock, rising edge
//   RESET           in   asynchronous active-low reset
//   MEM_READ        in   load request (level)
//   MEM_WRITE       in   store request (level, wins over MEM_READ)
//   MEM_ADDRESS     in   byte address (wraps modulo 4*DEPTH)
//   MEM_WRITE_DATA  in   store data
//   FUNC3           in   access width
//   READ_DATA       out  registered load result
//   BUSYWAIT        out  stall request to the CPU
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; a request is latched and BUSYWAIT raised at once
// ACCESS | counting down the remaining latency; inputs ignored
// DONE   | access complete, READ_DATA valid, requests not sampled
module data_memory
    import mem_defs::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit SINGLE = (LATENCY == 1);

    state_t state_q, state_d;

    logic [CW-1:0]   cnt_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      f3_q;
    logic            wr_q;

    logic            req;
    logic            last_cnt;
    logic            do_access;
    logic            use_live;
    logic [AW+1:0]   acc_addr;
    logic [31:0]     acc_wdata;
    logic [2:0]      acc_f3;
    logic            acc_wr;
    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word;
    logic [3:0]      byte_en;
    logic [31:0]     st_word;
    logic [31:0]     ld_data;
    logic            unused_addr_bits;

    logic [31:0] mem [DEPTH];

    assign req              = MEM_READ | MEM_WRITE;
    assign unused_addr_bits = ^MEM_ADDRESS[31:AW+2];

    // The counter is loaded with LATENCY-1 on entry; the edge whose decrement
    // takes it to zero is the one that performs the access.
    assign last_cnt = (cnt_q == CNT_ONE);

    // With LATENCY=1 the access happens at the accepting edge, so the live
    // inputs are used; otherwise the latched copies are.
    assign use_live  = (state_q == S_IDLE);
    assign acc_addr  = use_live ? MEM_ADDRESS[AW+1:0] : addr_q;
    assign acc_wdata = use_live ? MEM_WRITE_DATA      : wdata_q;
    assign acc_f3    = use_live ? FUNC3               : f3_q;
    assign acc_wr    = use_live ? MEM_WRITE           : wr_q;
    assign word_idx  = acc_addr[AW+1:2];
    assign rd_word   = mem[word_idx];

    assign do_access = RESET &
                       ((SINGLE && (state_q == S_IDLE) && req) ||
                        ((state_q == S_ACCESS) && last_cnt));

    load_store_align u_align (
        .func3   (acc_f3),
        .addr_lo (acc_addr[1:0]),
        .rd_word (rd_word),
        .wr_data (acc_wdata),
        .byte_en (byte_en),
        .st_word (st_word),
        .ld_data (ld_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = SINGLE ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (last_cnt) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RESET gates BUSYWAIT so it drops immediately even with a request held.
    always_comb begin
        BUSYWAIT = RESET & (((state_q == S_IDLE) & req) | (state_q == S_ACCESS));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        cnt_q   <= CNT_LOAD;
                        addr_q  <= MEM_ADDRESS[AW+1:0];
                        wdata_q <= MEM_WRITE_DATA;
                        f3_q    <= FUNC3;
                        wr_q    <= MEM_WRITE;
                    end
                end
                S_ACCESS: cnt_q <= cnt_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            READ_DATA <= '0;
        end else if (do_access && !acc_wr) begin
            READ_DATA <= ld_data;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        if (do_access && acc_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= st_word[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    logic        clk;
    logic        rst_n;

    logic        rd_4, wr_4;
    logic [31:0] addr_4, wdata_4;
    logic [2:0]  f3_4;
    logic [31:0] rdata_4;
    logic        busy_4;

    logic        rd_1, wr_1;
    logic [31:0] addr_1, wdata_1;
    logic [2:0]  f3_1;
    logic [31:0] rdata_1;
    logic        busy_1;

    int n_chk  = 0;
    int n_fail = 0;

    data_memory #(.DEPTH(256), .LATENCY(4)) u_dut4 (
        .CLK            (clk),
        .RESET          (rst_n),
        .MEM_READ       (rd_4),
        .MEM_WRITE      (wr_4),
        .MEM_ADDRESS    (addr_4),
        .MEM_WRITE_DATA (wdata_4),
        .FUNC3          (f3_4),
        .READ_DATA      (rdata_4),
        .BUSYWAIT       (busy_4)
    );

    data_memory #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .CLK            (clk),
        .RESET          (rst_n),
        .MEM_READ       (rd_1),
        .MEM_WRITE      (wr_1),
        .MEM_ADDRESS    (addr_1),
        .MEM_WRITE_DATA (wdata_1),
        .FUNC3          (f3_1),
        .READ_DATA      (rdata_1),
        .BUSYWAIT       (busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          lat1;
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit lat1, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        if (lat1) begin
            wr_1 = w; rd_1 = r; addr_1 = a; wdata_1 = d; f3_1 = f;
        end else begin
            wr_4 = w; rd_4 = r; addr_4 = a; wdata_4 = d; f3_4 = f;
        end
    endtask

    function automatic logic cur_busy(input bit lat1);
        return lat1 ? busy_1 : busy_4;
    endfunction

    // Presents a request in an IDLE cycle and counts BUSYWAIT-high cycles.
    // Returns sitting in the DONE cycle with the request still driven.
    task automatic run(input bit lat1, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       output int nb, output logic [31:0] rdv);
        @(negedge clk);
        drive(lat1, w, r, a, d, f);
        nb = 0;
        #1;
        while (cur_busy(lat1) && nb < 20) begin
            nb++;
            @(negedge clk);
            #1;
        end
        rdv = lat1 ? rdata_1 : rdata_4;
    endtask

    task automatic add(input string name, input bit lat1, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic [31:0] exp_rd);
        vec_t v;
        v.name = name; v.lat1 = lat1; v.w = w; v.r = r;
        v.a = a; v.d = d; v.f = f; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    initial begin
        int          nb;
        logic [31:0] rdv;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);

        //  name          lat1 w  r  addr          data          f3      expected READ_DATA
        add("init_w20",    0, 1, 0, 32'h0000_0020, 32'h0000_0000, 3'b010, 32'h0000_0000);
        add("sw_beef",     0, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000);
        add("lw_beef",     0, 0, 1, 32'h0000_0010, 32'h0000_0000, 3'b010, 32'hDEAD_BEEF);
        add("sb_23",       0, 1, 0, 32'h0000_0023, 32'hFFFF_FF80, 3'b000, 32'hDEAD_BEEF);
        add("sh_20",       0, 1, 0, 32'h0000_0020, 32'hABCD_1234, 3'b001, 32'hDEAD_BEEF);
        add("lw_20",       0, 0, 1, 32'h0000_0020, 32'h0000_0000, 3'b010, 32'h8000_1234);
        add("lb_23",       0, 0, 1, 32'h0000_0023, 32'h0000_0000, 3'b000, 32'hFFFF_FF80);
        add("lbu_23",      0, 0, 1, 32'h0000_0023, 32'h0000_0000, 3'b100, 32'h0000_0080);
        add("lh_20",       0, 0, 1, 32'h0000_0020, 32'h0000_0000, 3'b001, 32'h0000_1234);
        add("lhu_22",      0, 0, 1, 32'h0000_0022, 32'h0000_0000, 3'b101, 32'h0000_8000);
        add("lh_22",       0, 0, 1, 32'h0000_0022, 32'h0000_0000, 3'b001, 32'hFFFF_8000);
        add("lh_21",       0, 0, 1, 32'h0000_0021, 32'h0000_0000, 3'b001, 32'h0000_1234);
        add("lb_20",       0, 0, 1, 32'h0000_0020, 32'h0000_0000, 3'b000, 32'h0000_0034);
        add("lw_22",       0, 0, 1, 32'h0000_0022, 32'h0000_0000, 3'b010, 32'h8000_1234);
        add("lundef_20",   0, 0, 1, 32'h0000_0020, 32'h0000_0000, 3'b011, 32'h8000_1234);
        add("lbu_21",      0, 0, 1, 32'h0000_0021, 32'h0000_0000, 3'b100, 32'h0000_0012);
        add("rw_prio",     0, 1, 1, 32'h0000_0400, 32'hA5A5_A5A5, 3'b010, 32'h0000_0012);
        add("lw_wrap",     0, 0, 1, 32'h0000_0000, 32'h0000_0000, 3'b010, 32'hA5A5_A5A5);
        add("sb_wrap",     0, 1, 0, 32'h0000_0401, 32'h0000_007F, 3'b000, 32'hA5A5_A5A5);
        add("lw_0",        0, 0, 1, 32'h0000_0000, 32'h0000_0000, 3'b010, 32'hA5A5_7FA5);
        add("l1_sw",       1, 1, 0, 32'h0000_0008, 32'hCAFE_F00D, 3'b010, 32'h0000_0000);
        add("l1_lw",       1, 0, 1, 32'h0000_0008, 32'h0000_0000, 3'b010, 32'hCAFE_F00D);
        add("l1_sb",       1, 1, 0, 32'h0000_0009, 32'h0000_005A, 3'b000, 32'hCAFE_F00D);
        add("l1_lhu",      1, 0, 1, 32'h0000_0008, 32'h0000_0000, 3'b101, 32'h0000_5A0D);
        add("l1_lh_hi",    1, 0, 1, 32'h0000_000A, 32'h0000_0000, 3'b001, 32'hFFFF_CAFE);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy4", {31'b0, busy_4}, 32'h0);
        check("rst_rdata4", rdata_4, 32'h0);
        check("rst_busy1", {31'b0, busy_1}, 32'h0);
        check("rst_rdata1", rdata_1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run(vecs[i].lat1, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].f, nb, rdv);
            check({vecs[i].name, "_busy_cycles"}, 32'(nb), vecs[i].lat1 ? 32'd1 : 32'd4);
            check({vecs[i].name, "_rdata"}, rdv, vecs[i].exp_rd);
            drive(vecs[i].lat1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        end

        // Held read across DONE: one access, BUSYWAIT low in DONE, re-raised in next IDLE.
        run(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 3'b010, nb, rdv);
        check("held_busy_cycles", 32'(nb), 32'd4);
        check("held_done_busy", {31'b0, busy_4}, 32'h0);
        check("held_rdata", rdv, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        check("held_reassert", {31'b0, busy_4}, 32'h1);
        nb = 1;
        @(negedge clk);
        #1;
        while (busy_4 && nb < 20) begin
            nb++;
            @(negedge clk);
            #1;
        end
        check("held_second_cycles", 32'(nb), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);

        // Reset in the middle of a store: store dropped, older value survives.
        run(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h2222_2222, 3'b010, nb, rdv);
        check("pre_sw_cycles", 32'(nb), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h1111_1111, 3'b010);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_busy_before_rst", {31'b0, busy_4}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, busy_4}, 32'h0);
        check("rst_mid_rdata", rdata_4, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 3'b010, nb, rdv);
        check("post_rst_cycles", 32'(nb), 32'd4);
        check("post_rst_lw40", rdv, 32'h2222_2222);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory.md
# data_memory

Multi-cycle data memory that services the CPU's load/store requests at the MEM stage. It accepts a read or write, holds BUSYWAIT high for a fixed latency so that all pipeline registers stall, then completes the access. Byte, halfword and word accesses are supported, selected by the instruction's funct3. The block sits outside the CPU, opposite the CPU's MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITE_DATA outputs, and drives the CPU's READ_DATA and BUSYWAIT inputs.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, ≥4.
- LATENCY, 4: cycles BUSYWAIT is held per access; ≥1.
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- MEM_READ  in  1  load request, level.
- MEM_WRITE  in  1  store request, level.
- MEM_ADDRESS  in  32  byte address.
- MEM_WRITE_DATA  in  32  store data; low byte/half used for SB/SH.
- FUNC3  in  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- READ_DATA  out  32  registered load result, extended per FUNC3.
- BUSYWAIT  out  1  stall request to CPU.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: request = MEM_READ | MEM_WRITE.
  - On a request, latch address, data, FUNC3 and kind into internal registers.
  - Load the counter with LATENCY-1 and go to ACCESS. If LATENCY=1, go directly to DONE and perform the access at that edge.
- ACCESS: the counter decrements each cycle. When the counter is 0, perform the access at that edge and go to DONE. Input changes during ACCESS are ignored.
- DONE: lasts one cycle, then always returns to IDLE. Requests are not sampled in DONE, because the stalled CPU still presents the same request.
- Access when both MEM_READ and MEM_WRITE are high: write takes priority. No read is performed and READ_DATA is unchanged.
- Word index = addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4·DEPTH.
- Alignment:
  - Word ignores addr[1:0].
  - Halfword lane = addr[1]; addr[0] is ignored.
  - Byte lane = addr[1:0].
- Store merges only the selected byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes); other lanes are unchanged.
- Load, extended from the selected lane:
  - B/H: sign-extended.
  - BU/HU: zero-extended.
  - W: full word.
  - Undefined FUNC3 (011, 110, 111): treated as W.
- READ_DATA updates only on a completed read and holds otherwise.

## Timing
- Cycle 0 = the first IDLE cycle with a request.
- BUSYWAIT = (state==IDLE & request) | (state==ACCESS). It is combinational from the request in IDLE, so it is high in cycle 0 and stays high for exactly LATENCY cycles (0..LATENCY-1).
- The array write and READ_DATA load occur at the rising edge that ends cycle LATENCY-1.
- Cycle LATENCY is DONE: BUSYWAIT is low and READ_DATA is valid. The CPU's MEM_WB register captures READ_DATA at the end of this cycle.
- Back-to-back accesses: the next request is accepted in cycle LATENCY+1 at the earliest, giving a throughput of one access per LATENCY+1 cycles.
- Reset (RESET=0), at any time including mid-access:
  - State → IDLE, counter → 0, READ_DATA → 0, BUSYWAIT → 0 immediately (asynchronous).
  - An in-flight store is dropped.
  - Array contents are not cleared.
- First request after reset release: accepted in the first IDLE cycle in which it is present.

## Structure
- Shared defines/package `mem_defs`:
  - FUNC3 load/store width encodings.
  - FSM state encodings.
- Sub-module `load_store_align`: combinational. Inputs are FUNC3, addr[1:0], the stored word and the write data. Outputs are the 4-bit byte-enable, the merged store word and the extended load value.
- Top level holds the FSM, counter, latch registers and array.

## Test plan
- Word round trip (LATENCY=4): SW 0xDEADBEEF to 0x10, then LW 0x10. BUSYWAIT is high for 4 cycles per access, and READ_DATA=0xDEADBEEF in the DONE cycle.
- Byte/half lanes, starting from word 0x20 = 0x00000000:
  - SB 0x80 to 0x23, then SH 0x1234 to 0x20. LW 0x20 = 0x80001234.
  - LB 0x23 = 0xFFFFFF80.
  - LBU 0x23 = 0x00000080.
  - LH 0x20 = 0x00001234.
- Priority and wrap (DEPTH=256):
  - MEM_READ=MEM_WRITE=1, SW 0xA5A5A5A5 to 0x400: READ_DATA is unchanged.
  - A following LW 0x000 returns 0xA5A5A5A5 (address wrap).
- Held request: keep MEM_READ high across DONE. Exactly one access occurs, BUSYWAIT is low in DONE, and it re-asserts in the next IDLE cycle.
- Reset mid-store: assert RESET=0 in ACCESS cycle 2 of an SW 0x11111111 to 0x40 that was preceded by SW 0x22222222 to 0x40.
  - BUSYWAIT goes low at once and READ_DATA=0.
  - After release, LW 0x40 = 0x22222222.
- LATENCY=1: SW then LW. BUSYWAIT is high for one cycle per access, and READ_DATA is valid in the next cycle.
